multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences the MIPS datapath over FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Adds a parametrised memory-latency wait counter and illegal-opcode detection.
- Sits between the instruction register (opcode input) and the shared-memory multi-cycle datapath.

Parameters:
- MEM_LAT, 1, cycles each memory access state is held (must be >= 1)
- CNT_W, 4, width of the wait counter (2^CNT_W >= MEM_LAT)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from IR; sampled only in DECODE
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if ALU zero
- iord  out  1  memory address select (0 = PC, 1 = ALUOut)
- memread  out  1  memory read
- memwrite  out  1  memory write
- irwrite  out  1  IR load
- memtoreg  out  1  writeback select (1 = MDR)
- regdst  out  1  dest reg select (1 = rd)
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select (1 = reg A)
- alusrcb  out  2  ALU B select (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2)
- aluop  out  2  00 add, 01 sub, 10 funct
- pcsource  out  2  00 ALU, 01 ALUOut, 10 jump target
- illegal  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state (debug)

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- State encoding:
  - IDLE=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Reset:
  - rst_n low forces state=IDLE and waitcnt=0 immediately.
  - In IDLE all outputs are 0 and state=15.
  - First clk edge after release: IDLE->FETCH.
- Outputs are pure Moore decodes of state (plus waitcnt in FETCH). Any output not listed for a state is 0.
  - FETCH: memread=1, alusrcb=01; irwrite=1 and pcwrite=1 only when waitcnt==MEM_LAT-1.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: memread=1, iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: memwrite=1, iord=1 (held all wait cycles).
  - EXEC: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JUMP: pcwrite=1, pcsource=10.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
- Wait counter:
  - Applies in FETCH, MEMRD and MEMWR.
  - waitcnt clears on entry to the state and increments each cycle.
  - The state exits when waitcnt==MEM_LAT-1.
  - With MEM_LAT=1 each of these states lasts exactly 1 cycle.
- Transitions:
  - FETCH->DECODE.
  - DECODE on opcode:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDIEX (only if enabled)
    - else -> FETCH, with illegal=1 during that DECODE cycle
  - MEMADR -> MEMRD if opcode 100011, else MEMWR.
  - MEMRD->MEMWB. EXEC->ALUWB. ADDIEX->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB -> FETCH.
- Cycles per instruction (FETCH to next FETCH) at MEM_LAT=L:
  - R-type: L+3
  - lw: 2L+3
  - sw: 2L+2
  - beq and j: L+2
- Boundary conditions:
  - Reset asserted mid-instruction aborts at once; no partial write outputs remain asserted.
  - Opcode changes outside DECODE/MEMADR are ignored.
  - An unreachable state encoding recovers to IDLE on the next edge.

Optional Feature:
- Macro ADDI_EN.
- Defined: opcode 001000 follows DECODE->ADDIEX->ADDIWB->FETCH (L+3 cycles).
- Undefined: ADDIEX/ADDIWB logic is absent, and 001000 is treated as illegal (illegal pulse, return to FETCH).

Test Plan:
- Reset and R-type (MEM_LAT=1):
  - Stimulus: rst_n low then released, opcode=000000.
  - Response: state sequence 15,0,1,6,7,0. regwrite=1 and regdst=1 only in state 7. pcwrite high only in state 0.
- lw then sw (MEM_LAT=1):
  - Stimulus: opcode=100011, then 101011.
  - Response, lw: 0,1,2,3,4,0 with memtoreg=1 in 4.
  - Response, sw: 0,1,2,5,0 with memwrite=1 for exactly 1 cycle.
- beq and j:
  - Stimulus: opcode=000100, then 000010.
  - Response, beq: 0,1,8 with pcwritecond=1, aluop=01.
  - Response, j: 0,1,9 with pcwrite=1, pcsource=10; each instruction takes 3 cycles.
- Memory latency (MEM_LAT=3) with lw:
  - Response: FETCH lasts 3 cycles with irwrite/pcwrite high only in the 3rd; MEMRD lasts 3 cycles; total 9 cycles.
- Illegal opcode 111111:
  - Response: illegal=1 for exactly one DECODE cycle, next state 0, no regwrite/memwrite/pcwrite from that instruction.
  - Also: without ADDI_EN, opcode 001000 gives the same illegal behaviour.
- Async reset mid-MEMWR (MEM_LAT=3, second wait cycle):
  - Response: memwrite drops without waiting for clk, state=15; restart reaches FETCH on the next edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK with a memory-latency wait counter.
// Optional feature: define ADDI_EN to add the ADDIEX/ADDIWB path for opcode 001000.
module multicycle_control #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_IDLE   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT - 1);

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] waitcnt_reg, waitcnt_next;
    logic             wait_state;
    logic             wait_done;
    logic             op_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            waitcnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            waitcnt_reg <= waitcnt_next;
        end
    end

    // Counter returns to zero whenever a wait state exits, so each entry starts at 0.
    always_comb begin
        wait_state   = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
        wait_done    = (waitcnt_reg == WAIT_LAST);
        waitcnt_next = (wait_state && !wait_done) ? waitcnt_reg + CNT_W'(1) : '0;

        op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ) || (opcode == OP_J);
`ifdef ADDI_EN
        op_legal = op_legal || (opcode == OP_ADDI);
`endif

        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = wait_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_next = S_ADDIEX;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = wait_done ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = wait_done ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
`ifdef ADDI_EN
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
`endif
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal     = 1'b0;
        state       = state_reg;
        case (state_reg)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = wait_done;
                pcwrite = wait_done;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = !op_legal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
`ifdef ADDI_EN
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (MEM_LAT=1 and MEM_LAT=3) driven with directed and random
// opcode streams, checked cycle by cycle against an instruction-level model of the state walk.
module tb_multicycle_control;
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
                           MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
                           ADDIEX = 4'd10, ADDIWB = 4'd11, IDLE = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_r [2];
    logic [5:0] op_r [2];
    logic       pcwrite_w [2], pcwritecond_w [2], iord_w [2], memread_w [2], memwrite_w [2];
    logic       irwrite_w [2], memtoreg_w [2], regdst_w [2], regwrite_w [2], alusrca_w [2], illegal_w [2];
    logic [1:0] alusrcb_w [2], aluop_w [2], pcsource_w [2];
    logic [3:0] state_w [2];

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];
    logic [5:0] dir_ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111, 6'b001000};

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        multicycle_control #(.MEM_LAT(gi == 0 ? 1 : 3), .CNT_W(4)) dut (
            .clk(clk), .rst_n(rst_r[gi]), .opcode(op_r[gi]),
            .pcwrite(pcwrite_w[gi]), .pcwritecond(pcwritecond_w[gi]), .iord(iord_w[gi]),
            .memread(memread_w[gi]), .memwrite(memwrite_w[gi]), .irwrite(irwrite_w[gi]),
            .memtoreg(memtoreg_w[gi]), .regdst(regdst_w[gi]), .regwrite(regwrite_w[gi]),
            .alusrca(alusrca_w[gi]), .alusrcb(alusrcb_w[gi]), .aluop(aluop_w[gi]),
            .pcsource(pcsource_w[gi]), .illegal(illegal_w[gi]), .state(state_w[gi])
        );
    end

    // Packed view of all control outputs of one instance.
    function automatic logic [16:0] obs(input int s);
        return {pcwrite_w[s], pcwritecond_w[s], iord_w[s], memread_w[s], memwrite_w[s], irwrite_w[s],
                memtoreg_w[s], regdst_w[s], regwrite_w[s], alusrca_w[s], alusrcb_w[s], aluop_w[s],
                pcsource_w[s], illegal_w[s]};
    endfunction

    function automatic bit addi_on();
`ifdef ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
               op == 6'b000010 || (op == 6'b001000 && addi_on());
    endfunction

    // Whole-instruction state walk: L fetch cycles, decode, then the class-specific steps.
    function automatic void build_seq(input int lat, input logic [5:0] op);
        exp_q = {};
        repeat (lat) exp_q.push_back(FETCH);
        exp_q.push_back(DECODE);
        if (op == 6'b000000) begin
            exp_q.push_back(EXEC); exp_q.push_back(ALUWB);
        end else if (op == 6'b100011) begin
            exp_q.push_back(MEMADR);
            repeat (lat) exp_q.push_back(MEMRD);
            exp_q.push_back(MEMWB);
        end else if (op == 6'b101011) begin
            exp_q.push_back(MEMADR);
            repeat (lat) exp_q.push_back(MEMWR);
        end else if (op == 6'b000100) exp_q.push_back(BRANCH);
        else if (op == 6'b000010) exp_q.push_back(JUMP);
        else if (op == 6'b001000 && addi_on()) begin
            exp_q.push_back(ADDIEX); exp_q.push_back(ADDIWB);
        end
    endfunction

    // Expected control word for a state; idx is the cycle number inside the instruction.
    function automatic logic [16:0] exp_ctl(input logic [3:0] st, input int idx, input int lat, input logic [5:0] op);
        logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, ir = 0, m2r = 0, rd = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] sb = 0, ao = 0, ps = 0;
        case (st)
            FETCH:  begin mr = 1; sb = 2'b01; ir = (idx == lat - 1); pw = (idx == lat - 1); end
            DECODE: begin sb = 2'b11; ill = !is_legal(op); end
            MEMADR: begin sa = 1; sb = 2'b10; end
            MEMRD:  begin mr = 1; io = 1; end
            MEMWB:  begin m2r = 1; rw = 1; end
            MEMWR:  begin mw = 1; io = 1; end
            EXEC:   begin sa = 1; ao = 2'b10; end
            ALUWB:  begin rd = 1; rw = 1; end
            BRANCH: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            JUMP:   begin pw = 1; ps = 2'b10; end
            ADDIEX: begin sa = 1; sb = 2'b10; end
            ADDIWB: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, ir, m2r, rd, rw, sa, sb, ao, ps, ill};
    endfunction

    task automatic test_reset();
        rst_r[0] = 1'b0; rst_r[1] = 1'b0;
        op_r[0] = 6'b000000; op_r[1] = 6'b000000;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (state_w[s] !== IDLE) begin
                bad++; $display("FAIL reset_state[%0d]: got %0d want 15", s, state_w[s]);
            end
            total++;
            if (obs(s) !== 17'd0) begin
                bad++; $display("FAIL reset_outputs[%0d]: got %h want 0", s, obs(s));
            end
        end
        $display("reset: both instances checked in IDLE");
    endtask

    // Opcode is only meaningful in DECODE/MEMADR; every other cycle it carries random junk.
    task automatic test_instr_stream(input int sel, input int n, input bit rnd);
        int lat;
        logic [5:0] op;
        lat = (sel == 0) ? 1 : 3;
        rst_r[sel] = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (!rnd) op = dir_ops[k % 7];
            else if ($urandom_range(0, 9) < 7) op = dir_ops[$urandom_range(0, 6)];
            else op = 6'($urandom);
            build_seq(lat, op);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(posedge clk); #1;
                op_r[sel] = (exp_q[i] == DECODE || exp_q[i] == MEMADR) ? op : 6'($urandom);
                @(negedge clk);
                total++;
                if (state_w[sel] !== exp_q[i]) begin
                    bad++; $display("FAIL state L=%0d op=%b cyc=%0d: got %0d want %0d", lat, op, i, state_w[sel], exp_q[i]);
                end
                total++;
                if (obs(sel) !== exp_ctl(exp_q[i], i, lat, op)) begin
                    bad++; $display("FAIL ctl L=%0d op=%b cyc=%0d: got %h want %h", lat, op, i, obs(sel), exp_ctl(exp_q[i], i, lat, op));
                end
            end
            $display("instr L=%0d op=%b cycles=%0d", lat, op, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] op = 6'b101011;
        build_seq(3, op);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            op_r[1] = (exp_q[i] == DECODE || exp_q[i] == MEMADR) ? op : 6'($urandom);
            @(negedge clk);
            total++;
            if (state_w[1] !== exp_q[i]) begin
                bad++; $display("FAIL async_walk cyc=%0d: got %0d want %0d", i, state_w[1], exp_q[i]);
            end
        end
        total++;
        if (memwrite_w[1] !== 1'b1) begin
            bad++; $display("FAIL async_pre memwrite: got %b want 1", memwrite_w[1]);
        end
        #2 rst_r[1] = 1'b0;
        #1;
        total++;
        if (state_w[1] !== IDLE) begin
            bad++; $display("FAIL async_state: got %0d want 15", state_w[1]);
        end
        total++;
        if (obs(1) !== 17'd0) begin
            bad++; $display("FAIL async_outputs: got %h want 0", obs(1));
        end
        #1 rst_r[1] = 1'b1;
        @(negedge clk);
        total++;
        if (state_w[1] !== FETCH) begin
            bad++; $display("FAIL async_restart: got %0d want 0", state_w[1]);
        end
        $display("async reset mid-MEMWR: restart checked");
    endtask

    initial begin
        test_reset();
        test_instr_stream(0, 7, 1'b0);
        test_instr_stream(0, 40, 1'b1);
        test_instr_stream(1, 7, 1'b0);
        test_instr_stream(1, 25, 1'b1);
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
